reg_file_wb: RTL

// - Integer register file for the RISC-V core: 2 async read ports, 1 sync write port.
// - Write port is driven directly by the 5-bit write-back destination selector output.
// - A post-reset clear sequencer zeroes x1..x31, one register per cycle, then raises ready.
// - Write-to-read bypass lets decode see a same-cycle write-back value; x0 is hardwired to zero.
//

---
 rtl/reg_file_wb_if.sv | 31 +++
 rtl/reg_file_wb.sv | 111 +++++++++++
 2 files changed

// File: rtl/reg_file_wb_if.sv
// Register file bus: write-back port, two read ports and the ready flag.
//   master : drives write-back and read addresses (core / testbench)
//   slave  : the register file
// Ports (all inside the interface):
//   wr_en, wr_addr, wr_data    write-back request
//   rd_addr_a, rd_addr_b       read addresses (rs1, rs2)
//   rd_data_a, rd_data_b       combinational read data
//   ready                      1 once the post-reset clear has finished
interface reg_file_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              ready;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, ready
  );
endinterface

// File: rtl/reg_file_wb.sv
// Integer register file: two combinational read ports, one synchronous
// write-back port, x0 hardwired to zero, write-to-read bypass, and a
// post-reset sequencer that zeroes x1..x31 one per cycle before raising ready.
// Ports:
//   clk    core clock, all state on posedge
//   rst_n  synchronous reset, active low
//   bus    reg_file_wb_if.slave (write-back, read ports, ready)
//
// state | meaning
// CLEAR | zeroing regs[clr_ptr], one per cycle; reads return 0, writes ignored
// RUN   | operational; only rst_n==0 leaves it
module reg_file_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_wb_if.slave  bus
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              ready;
  logic              wr_live;
  logic [DATA_W-1:0] rd_a, rd_b;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= ADDR_W'(1);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_REG) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign ready = (state_q == RUN);

  // A write is live only in RUN with reset released; the same qualifier
  // gates the bypass so a write that will be dropped is never forwarded.
  assign wr_live = rst_n && ready && bus.wr_en;

  // Register array has no reset; the clear sequencer owns zeroing it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        regs[clr_ptr_q] <= '0;
      end else if (bus.wr_en && (bus.wr_addr != '0)) begin
        regs[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Read ports: not-ready -> 0, x0 -> 0, bypass, then array.
  always_comb begin
    rd_a = '0;
    if (ready && (bus.rd_addr_a != '0)) begin
      if (wr_live && (bus.wr_addr == bus.rd_addr_a)) begin
        rd_a = bus.wr_data;
      end else begin
        rd_a = regs[bus.rd_addr_a];
      end
    end
  end

  always_comb begin
    rd_b = '0;
    if (ready && (bus.rd_addr_b != '0)) begin
      if (wr_live && (bus.wr_addr == bus.rd_addr_b)) begin
        rd_b = bus.wr_data;
      end else begin
        rd_b = regs[bus.rd_addr_b];
      end
    end
  end

  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;
  assign bus.ready     = ready;

endmodule
